scp_alarm_escalator: RTL and testbench
======================================

// Module: scp_alarm_escalator
// PURPOSE
//  Downstream consumer of scp_079 alarm outputs (a1, a2, a3, cheat_out).
//  Converts level alarms into rising-edge events, escalates through WARN/ALERT/LOCKDOWN
//  on priority and dwell timeouts, and counts events.
//  Drives siren level and lockdown to the operator panel; clock is the 1 Hz system tick.
// PARAMETERS
//  WARN_TIMEOUT  10  cycles in WARN without valid ack before ALERT
//  ALERT_TIMEOUT 20  cycles in ALERT without valid ack before LOCKDOWN
//  LOCK_THRESH   3   event count that forces LOCKDOWN from any state
//  CNT_W         4   width of saturating event counter
// PORTS
//  clock      in   1      system clock, rising edge
//  reset_n    in   1      asynchronous, active-low reset
//  a1         in   1      alarm level 1 from scp_079
//  a2         in   1      alarm level 2 from scp_079
//  a3         in   1      alarm level 3 from scp_079
//  cheat_in   in   1      cheat_out from scp_079
//  ack        in   1      operator acknowledge, level, sampled each edge
//  clear_lock in   1      supervisor key; exits LOCKDOWN
//  esc_state  out  2      0 IDLE, 1 WARN, 2 ALERT, 3 LOCKDOWN
//  siren      out  2      equals esc_state (registered copy)
//  lockdown   out  1      1 iff esc_state==LOCKDOWN
//  last_src   out  3      0 none, 1 a1, 2 a2, 3 a3, 4 cheat
//  evt_count  out  CNT_W  saturating count of accepted events
// BEHAVIOUR
//  Reset: all outputs 0, dwell 0, prev-input regs 0.
//   An input already high at reset release is a rising edge on the first clock.
//  Event: rise = in & ~prev, evaluated per input each edge. Priority cheat > a3 > a2 > a1.
//   Max one event per cycle; last_src takes the winning source.
//   evt_count +1 per event cycle, saturates at 2**CNT_W-1.
//  Latency: input first sampled high at edge k -> state/outputs updated at edge k. Outputs registered.
//  Alarm-active (act): a1|a2|a3|cheat_in level.
//   Valid ack: ack==1 & act==0 in the same cycle.
//  FSM, evaluated in order; first match wins:
//   1. evt_count+event >= LOCK_THRESH -> LOCKDOWN
//   2. cheat rise -> LOCKDOWN
//   3. IDLE:  a3 rise -> ALERT; a1/a2 rise -> WARN
//   4. WARN:  a3 rise -> ALERT; valid ack -> IDLE; dwell==WARN_TIMEOUT-1 -> ALERT
//   5. ALERT: valid ack -> IDLE; dwell==ALERT_TIMEOUT-1 -> LOCKDOWN
//   6. LOCKDOWN: clear_lock & ~act -> IDLE; evt_count and last_src clear to 0 on that edge.
//      All else ignored, including ack and new events (counter still counts, saturating).
//  Dwell counter: $clog2(ALERT_TIMEOUT) bits; 0 on every state change; else +1.
//   Not reset by further events in the same state.
//  Simultaneous: a new event beats ack in the same cycle (ack is invalid anyway, since act=1).
//   clear_lock in a non-LOCKDOWN state: no effect.
//  Reset asserted mid-operation: immediate return to reset values, no clock needed.
// STRUCTURE
//  Shared header scp_alarm_defs.vh:
//   state codes (S_IDLE..S_LOCKDOWN)
//   source codes (SRC_NONE..SRC_CHEAT)
//  Sub-module scp_rise_detect: 4-bit prev register plus rise vector, async clear on reset_n.
//  Top holds the priority encoder, FSM, dwell counter and event counter.
// TESTING
//  1. Reset, then a1=1 at t=2 -> esc_state=1, last_src=1, evt_count=1 at that edge.
//     Hold a1=1 for 10 cycles -> esc_state=2.
//  2. WARN, a1 drops, ack=1 one cycle -> esc_state=0, evt_count stays 1.
//     ack while a1=1 -> no change.
//  3. a3 rise from IDLE -> ALERT (2), last_src=3.
//     No valid ack for 20 cycles -> LOCKDOWN, lockdown=1.
//  4. a1, a2, a3 all rise in the same cycle -> last_src=3, evt_count +1 only.
//     Three separate alarm pulses -> LOCKDOWN at the 3rd.
//  5. cheat_in rise in any state -> LOCKDOWN next edge.
//     clear_lock=1 with cheat_in=1 -> stays.
//     clear_lock=1 with all alarms 0 -> IDLE, evt_count=0, last_src=0.
//  6. In ALERT with dwell=7, pulse reset_n=0 between edges -> all outputs 0 immediately.
//     a2 still high at release -> WARN on first edge.

Source files
------------

// File: rtl/scp_alarm_escalator_pkg.sv
// Shared escalation state and alarm-source codes for the scp_079 alarm consumer.
// Used by the escalator top and its edge detector.
package scp_alarm_escalator_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WARN     = 2'd1,
        S_ALERT    = 2'd2,
        S_LOCKDOWN = 2'd3
    } esc_state_e;

    typedef enum logic [2:0] {
        SRC_NONE  = 3'd0,
        SRC_A1    = 3'd1,
        SRC_A2    = 3'd2,
        SRC_A3    = 3'd3,
        SRC_CHEAT = 3'd4
    } src_e;

    // Bit positions of the alarm inputs inside the rise vector.
    localparam int unsigned IDX_A1    = 0;
    localparam int unsigned IDX_A2    = 1;
    localparam int unsigned IDX_A3    = 2;
    localparam int unsigned IDX_CHEAT = 3;
    localparam int unsigned N_SRC     = 4;

    // Priority cheat > a3 > a2 > a1.
    function automatic src_e pick_src(input logic [N_SRC-1:0] rise);
        if (rise[IDX_CHEAT])   return SRC_CHEAT;
        else if (rise[IDX_A3]) return SRC_A3;
        else if (rise[IDX_A2]) return SRC_A2;
        else if (rise[IDX_A1]) return SRC_A1;
        else                   return SRC_NONE;
    endfunction

endpackage

// File: rtl/scp_rise_detect.sv
// Per-bit rising-edge detector: previous-sample register plus combinational rise vector.
// Prev clears to 0 on reset, so an input already high at release reports a rise on the first edge.
module scp_rise_detect #(
    parameter int unsigned W = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [W-1:0] in_vec,
    output logic [W-1:0] rise
);

    logic [W-1:0] prev_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) prev_q <= '0;
        else          prev_q <= in_vec;
    end

    always_comb rise = in_vec & ~prev_q;

endmodule

// File: rtl/scp_alarm_escalator.sv
// Escalates scp_079 alarm edges through WARN/ALERT/LOCKDOWN with dwell timeouts,
// tracks the latest source and a saturating event count; all outputs registered.
module scp_alarm_escalator
    import scp_alarm_escalator_pkg::*;
#(
    parameter int unsigned WARN_TIMEOUT  = 10,
    parameter int unsigned ALERT_TIMEOUT = 20,
    parameter int unsigned LOCK_THRESH   = 3,
    parameter int unsigned CNT_W         = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             a1,
    input  logic             a2,
    input  logic             a3,
    input  logic             cheat_in,
    input  logic             ack,
    input  logic             clear_lock,
    output logic [1:0]       esc_state,
    output logic [1:0]       siren,
    output logic             lockdown,
    output logic [2:0]       last_src,
    output logic [CNT_W-1:0] evt_count
);

    localparam int unsigned DW = $clog2(ALERT_TIMEOUT);

    logic [N_SRC-1:0] in_vec;
    logic [N_SRC-1:0] rise;

    esc_state_e       state_q, state_d;
    src_e             src_q, src_d;
    logic [DW-1:0]    dwell_q, dwell_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       siren_q;
    logic             lock_q;

    logic             evt, act, ack_ok, lock_hit, clear_ok;
    logic [CNT_W:0]   cnt_sum;

    always_comb begin
        in_vec            = '0;
        in_vec[IDX_A1]    = a1;
        in_vec[IDX_A2]    = a2;
        in_vec[IDX_A3]    = a3;
        in_vec[IDX_CHEAT] = cheat_in;
    end

    scp_rise_detect #(.W(N_SRC)) u_rise (
        .clock   (clock),
        .reset_n (reset_n),
        .in_vec  (in_vec),
        .rise    (rise)
    );

    always_comb begin
        evt      = |rise;
        act      = |in_vec;
        ack_ok   = ack & ~act;
        cnt_sum  = {1'b0, cnt_q} + {{CNT_W{1'b0}}, evt};
        lock_hit = 32'(cnt_sum) >= LOCK_THRESH;
        clear_ok = 1'b0;
        state_d  = state_q;

        // LOCKDOWN exit is checked before the threshold rule; otherwise a count
        // already at threshold would make the supervisor key unusable.
        if (state_q == S_LOCKDOWN) begin
            if (clear_lock && !act) begin
                state_d  = S_IDLE;
                clear_ok = 1'b1;
            end
        end else if (lock_hit || rise[IDX_CHEAT]) begin
            state_d = S_LOCKDOWN;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (rise[IDX_A3])                        state_d = S_ALERT;
                    else if (rise[IDX_A1] || rise[IDX_A2])   state_d = S_WARN;
                end
                S_WARN: begin
                    if (rise[IDX_A3])                             state_d = S_ALERT;
                    else if (ack_ok)                              state_d = S_IDLE;
                    else if (dwell_q == DW'(WARN_TIMEOUT - 1))    state_d = S_ALERT;
                end
                S_ALERT: begin
                    if (ack_ok)                                   state_d = S_IDLE;
                    else if (dwell_q == DW'(ALERT_TIMEOUT - 1))   state_d = S_LOCKDOWN;
                end
                default: state_d = state_q;
            endcase
        end

        dwell_d = (state_d != state_q) ? '0 : dwell_q + DW'(1);

        cnt_d = cnt_q;
        if (clear_ok)                cnt_d = '0;
        else if (evt && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);

        src_d = src_q;
        if (clear_ok) src_d = SRC_NONE;
        else if (evt) src_d = pick_src(rise);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            src_q   <= SRC_NONE;
            dwell_q <= '0;
            cnt_q   <= '0;
            siren_q <= '0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dwell_q <= dwell_d;
            cnt_q   <= cnt_d;
            siren_q <= state_d;
            lock_q  <= (state_d == S_LOCKDOWN);
        end
    end

    assign esc_state = state_q;
    assign siren     = siren_q;
    assign lockdown  = lock_q;
    assign last_src  = src_q;
    assign evt_count = cnt_q;

endmodule

// File: tb/tb_scp_alarm_escalator.sv
// Directed bench for scp_alarm_escalator: hand-computed expectations for escalation,
// acks, timeouts, priority, saturation, lockdown clear and asynchronous reset.
module tb_scp_alarm_escalator;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       a1 = 1'b0, a2 = 1'b0, a3 = 1'b0, cheat_in = 1'b0;
    logic       ack = 1'b0, clear_lock = 1'b0;
    logic [1:0] esc_state, siren;
    logic       lockdown;
    logic [2:0] last_src;
    logic [3:0] evt_count;

    int unsigned total = 0;
    int unsigned bad   = 0;

    scp_alarm_escalator #(
        .WARN_TIMEOUT  (10),
        .ALERT_TIMEOUT (20),
        .LOCK_THRESH   (3),
        .CNT_W         (4)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .a1         (a1),
        .a2         (a2),
        .a3         (a3),
        .cheat_in   (cheat_in),
        .ack        (ack),
        .clear_lock (clear_lock),
        .esc_state  (esc_state),
        .siren      (siren),
        .lockdown   (lockdown),
        .last_src   (last_src),
        .evt_count  (evt_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [1:0] st,
                              input logic [2:0] src, input logic [3:0] cnt);
        check({tag, ".state"}, 32'(esc_state), 32'(st));
        check({tag, ".siren"}, 32'(siren), 32'(st));
        check({tag, ".lock"},  32'(lockdown), 32'(st == 2'd3));
        check({tag, ".src"},   32'(last_src), 32'(src));
        check({tag, ".cnt"},   32'(evt_count), 32'(cnt));
    endtask

    task automatic tick(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        {a1, a2, a3, cheat_in, ack, clear_lock} = '0;
        #2;
        expect_out("reset", 2'd0, 3'd0, 4'd0);
        reset_n = 1'b1;
    endtask

    initial begin
        // 1: a1 rise -> WARN at that edge, then WARN timeout -> ALERT
        do_reset();
        a1 = 1'b1; tick(1);
        expect_out("t1.warn", 2'd1, 3'd1, 4'd1);
        tick(9);
        expect_out("t1.warn_hold", 2'd1, 3'd1, 4'd1);
        tick(1);
        expect_out("t1.alert", 2'd2, 3'd1, 4'd1);

        // 2: ack ignored while alarm active, valid ack returns to IDLE
        do_reset();
        a1 = 1'b1; tick(1);
        ack = 1'b1; tick(1);
        expect_out("t2.ack_active", 2'd1, 3'd1, 4'd1);
        a1 = 1'b0; tick(1);
        expect_out("t2.ack_ok", 2'd0, 3'd1, 4'd1);
        ack = 1'b0;

        // 3: a3 -> ALERT, ALERT timeout -> LOCKDOWN
        do_reset();
        a3 = 1'b1; tick(1);
        expect_out("t3.alert", 2'd2, 3'd3, 4'd1);
        tick(19);
        expect_out("t3.alert_hold", 2'd2, 3'd3, 4'd1);
        tick(1);
        expect_out("t3.lock", 2'd3, 3'd3, 4'd1);

        // 4: simultaneous rises count once, threshold reached on the third event
        do_reset();
        {a1, a2, a3} = 3'b111; tick(1);
        expect_out("t4.multi", 2'd2, 3'd3, 4'd1);
        {a1, a2, a3} = 3'b000; tick(1);
        a1 = 1'b1; tick(1);
        expect_out("t4.second", 2'd2, 3'd1, 4'd2);
        a1 = 1'b0; tick(1);
        a2 = 1'b1; tick(1);
        expect_out("t4.third", 2'd3, 3'd2, 4'd3);
        a2 = 1'b0;

        // 5: cheat -> LOCKDOWN, saturation, clear blocked by alarm, then clear
        do_reset();
        cheat_in = 1'b1; tick(1);
        expect_out("t5.cheat", 2'd3, 3'd4, 4'd1);
        for (int unsigned i = 0; i < 20; i++) begin
            a1 = 1'b1; tick(1);
            a1 = 1'b0; tick(1);
        end
        expect_out("t5.sat", 2'd3, 3'd1, 4'd15);
        clear_lock = 1'b1; tick(1);
        expect_out("t5.clear_blocked", 2'd3, 3'd1, 4'd15);
        cheat_in = 1'b0; tick(1);
        expect_out("t5.clear", 2'd0, 3'd0, 4'd0);
        a1 = 1'b1; tick(1);
        expect_out("t5.clear_nolock", 2'd1, 3'd1, 4'd1);
        clear_lock = 1'b0;
        cheat_in = 1'b1; tick(1);
        expect_out("t5.cheat_warn", 2'd3, 3'd4, 4'd2);

        // 6: async reset mid-ALERT, a2 high at release is a rise on first edge
        do_reset();
        a3 = 1'b1; tick(1);
        tick(7);
        a2 = 1'b1; tick(1);
        expect_out("t6.pre", 2'd2, 3'd2, 4'd2);
        #2;
        reset_n = 1'b0;
        #1;
        expect_out("t6.async", 2'd0, 3'd0, 4'd0);
        a3 = 1'b0;
        #1;
        reset_n = 1'b1;
        tick(1);
        expect_out("t6.release", 2'd1, 3'd2, 4'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
